// File: rtl/front_panel_sequencer.sv
// rtl/front_panel_sequencer.sv - Altair front-panel command sequencer and memory-port arbiter
module front_panel_sequencer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int RESET_CYCLES    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        on_off_sw,
    input  logic        stop_run_sw,
    input  logic        step_sw,
    input  logic        examine_sw,
    input  logic        examine_next_sw,
    input  logic        deposit_sw,
    input  logic        deposit_next_sw,
    input  logic        reset_sw,
    input  logic        clear_sw,
    input  logic [7:0]  sense_addr_sw,
    input  logic [7:0]  data_addr_sw,
    input  logic        cpu_idle,
    output logic        cpu_run,
    output logic        cpu_step,
    output logic        cpu_reset,
    output logic        io_clear,
    output logic        panel_owns_bus,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic [15:0] panel_addr,
    output logic [7:0]  panel_data,
    output logic        wait_led
);
    localparam int NSW  = 8;
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RC_W = $clog2(RESET_CYCLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_GRANT, S_EXAM, S_DEP, S_READBACK, S_STEP, S_RST} state_t;
    typedef enum logic [2:0] {OP_EXAM, OP_EXAM_NEXT, OP_DEP, OP_DEP_NEXT, OP_STEP} op_t;

    logic                     rst;
    logic [NSW-1:0]           raw_sw;
    logic [NSW-1:0]           sync1_q, sync1_d, sync2_q, sync2_d, stable_q, stable_d;
    logic [NSW-2:0]           prev_q, prev_d, evt;
    logic [NSW-1:0][DB_W-1:0] cnt_q, cnt_d;
    state_t                   state_q, state_d;
    op_t                      op_q, op_d;
    logic [RC_W-1:0]          rst_cnt_q, rst_cnt_d;
    logic                     seen_busy_q, seen_busy_d;
    logic                     cpu_step_q, cpu_step_d, cpu_reset_q, cpu_reset_d;
    logic                     io_clear_q, io_clear_d, owns_q, owns_d;
    logic                     mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [15:0]              mem_addr_q, mem_addr_d;
    logic [7:0]               mem_wdata_q, mem_wdata_d, panel_data_q, panel_data_d;
    logic                     run_lvl, ack;

    assign rst    = reset | on_off_sw;
    // bit 7 is the stop/run level; bits 6..0 are momentary switches in rising priority
    assign raw_sw = {stop_run_sw, reset_sw, clear_sw, deposit_next_sw, deposit_sw,
                     examine_next_sw, examine_sw, step_sw};

    always_comb begin
        sync1_d  = raw_sw;
        sync2_d  = sync1_q;
        prev_d   = stable_q[NSW-2:0];
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < NSW; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    assign evt     = stable_q[NSW-2:0] & ~prev_q;
    assign run_lvl = stable_q[NSW-1];
    assign cpu_run = run_lvl && (state_q == S_IDLE);
    assign ack     = mem_ack && mem_req_q;

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        rst_cnt_d    = rst_cnt_q;
        seen_busy_d  = seen_busy_q;
        cpu_step_d   = 1'b0;
        io_clear_d   = 1'b0;
        cpu_reset_d  = cpu_reset_q;
        owns_d       = owns_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        panel_data_d = panel_data_q;
        case (state_q)
            S_IDLE: begin
                if (evt[5]) begin
                    io_clear_d = 1'b1;
                end else if (!cpu_run) begin
                    if (evt[4])      begin op_d = OP_DEP_NEXT;  state_d = S_GRANT; end
                    else if (evt[3]) begin op_d = OP_DEP;       state_d = S_GRANT; end
                    else if (evt[2]) begin op_d = OP_EXAM_NEXT; state_d = S_GRANT; end
                    else if (evt[1]) begin op_d = OP_EXAM;      state_d = S_GRANT; end
                    else if (evt[0]) begin op_d = OP_STEP;      state_d = S_GRANT; end
                end
            end
            S_GRANT: begin
                if (cpu_idle) begin
                    if (op_q == OP_STEP) begin
                        cpu_step_d  = 1'b1;
                        seen_busy_d = 1'b0;
                        state_d     = S_STEP;
                    end else begin
                        owns_d    = 1'b1;
                        mem_req_d = 1'b1;
                        mem_we_d  = (op_q == OP_DEP) || (op_q == OP_DEP_NEXT);
                        case (op_q)
                            OP_EXAM:                   mem_addr_d = {sense_addr_sw, data_addr_sw};
                            OP_EXAM_NEXT, OP_DEP_NEXT: mem_addr_d = mem_addr_q + 16'd1;
                            default:                   mem_addr_d = mem_addr_q;
                        endcase
                        if (mem_we_d) begin
                            mem_wdata_d = data_addr_sw;
                            state_d     = S_DEP;
                        end else begin
                            state_d = S_EXAM;
                        end
                    end
                end
            end
            S_EXAM: begin
                if (ack) begin
                    panel_data_d = mem_rdata;
                    mem_req_d    = 1'b0;
                    owns_d       = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            S_DEP: begin
                if (ack) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = S_READBACK;
                end
            end
            S_READBACK: begin
                // one idle cycle between the write and the read keeps requests distinct
                if (!mem_req_q) begin
                    mem_req_d = 1'b1;
                end else if (ack) begin
                    panel_data_d = mem_rdata;
                    mem_req_d    = 1'b0;
                    owns_d       = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            S_STEP: begin
                if (!cpu_idle) begin
                    seen_busy_d = 1'b1;
                end else if (seen_busy_q) begin
                    state_d = S_IDLE;
                end
            end
            S_RST: begin
                if (rst_cnt_q == RC_W'(RESET_CYCLES - 1)) begin
                    cpu_reset_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (evt[6]) begin
            state_d      = S_RST;
            rst_cnt_d    = '0;
            cpu_reset_d  = 1'b1;
            cpu_step_d   = 1'b0;
            io_clear_d   = 1'b0;
            owns_d       = 1'b0;
            mem_req_d    = 1'b0;
            mem_we_d     = 1'b0;
            mem_addr_d   = 16'h0000;
            panel_data_d = 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            stable_q     <= '0;
            prev_q       <= '0;
            cnt_q        <= '0;
            state_q      <= S_IDLE;
            op_q         <= OP_EXAM;
            rst_cnt_q    <= '0;
            seen_busy_q  <= 1'b0;
            cpu_step_q   <= 1'b0;
            cpu_reset_q  <= 1'b0;
            io_clear_q   <= 1'b0;
            owns_q       <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 16'h0000;
            mem_wdata_q  <= 8'h00;
            panel_data_q <= 8'h00;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            stable_q     <= stable_d;
            prev_q       <= prev_d;
            cnt_q        <= cnt_d;
            state_q      <= state_d;
            op_q         <= op_d;
            rst_cnt_q    <= rst_cnt_d;
            seen_busy_q  <= seen_busy_d;
            cpu_step_q   <= cpu_step_d;
            cpu_reset_q  <= cpu_reset_d;
            io_clear_q   <= io_clear_d;
            owns_q       <= owns_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            panel_data_q <= panel_data_d;
        end
    end

    assign cpu_step       = cpu_step_q;
    assign cpu_reset      = cpu_reset_q;
    assign io_clear       = io_clear_q;
    assign panel_owns_bus = owns_q;
    assign mem_req        = mem_req_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign panel_addr     = mem_addr_q;
    assign panel_data     = panel_data_q;
    assign wait_led       = ~cpu_run;
endmodule

// File: tb/tb_front_panel_sequencer.sv
// tb/tb_front_panel_sequencer.sv - table-driven and scoreboard bench for front_panel_sequencer
module tb_front_panel_sequencer;
    localparam int DB = 16;
    localparam int RC = 8;

    logic        clk = 1'b0;
    logic        reset, on_off_sw, stop_run_sw;
    logic        step_sw, examine_sw, examine_next_sw, deposit_sw, deposit_next_sw, reset_sw, clear_sw;
    logic [7:0]  sense_addr_sw, data_addr_sw;
    logic        cpu_idle;
    logic        cpu_run, cpu_step, cpu_reset, io_clear, panel_owns_bus, mem_req, mem_we;
    logic [15:0] mem_addr, panel_addr;
    logic [7:0]  mem_wdata, panel_data;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        wait_led;

    front_panel_sequencer #(.DEBOUNCE_CYCLES(DB), .RESET_CYCLES(RC)) dut (
        .clk(clk), .reset(reset), .on_off_sw(on_off_sw), .stop_run_sw(stop_run_sw),
        .step_sw(step_sw), .examine_sw(examine_sw), .examine_next_sw(examine_next_sw),
        .deposit_sw(deposit_sw), .deposit_next_sw(deposit_next_sw), .reset_sw(reset_sw),
        .clear_sw(clear_sw), .sense_addr_sw(sense_addr_sw), .data_addr_sw(data_addr_sw),
        .cpu_idle(cpu_idle), .cpu_run(cpu_run), .cpu_step(cpu_step), .cpu_reset(cpu_reset),
        .io_clear(io_clear), .panel_owns_bus(panel_owns_bus), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .panel_addr(panel_addr), .panel_data(panel_data), .wait_led(wait_led)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } txn_t;

    typedef struct packed {
        logic [2:0]  sw;
        logic [7:0]  sense;
        logic [7:0]  data;
        logic [7:0]  pre;
        logic [15:0] addr;
        logic [7:0]  pdata;
    } vec_t;

    txn_t        sb_q[$];
    vec_t        vecs[7];
    logic [7:0]  mem [0:65535];
    int          total = 0, bad = 0;
    int          req_count = 0, step_pulses = 0, step_run = 0, step_wmax = 0;
    int          clr_pulses = 0, clr_run = 0, clr_wmax = 0, rst_run = 0, rst_last = 0;
    int          r0, p0, c0, n, viol, busy_cnt = 0, lat = 0;
    logic        pending = 1'b0, ack_en = 1'b1, inject_ack = 1'b0, cpu_model_en = 1'b1;
    logic        req_prev = 1'b0;
    logic [24:0] req_snap = '0;
    txn_t        t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_sw(input int idx, input logic v);
        case (idx)
            0: step_sw         = v;
            1: examine_sw      = v;
            2: examine_next_sw = v;
            3: deposit_sw      = v;
            4: deposit_next_sw = v;
            5: clear_sw        = v;
            default: reset_sw  = v;
        endcase
    endtask

    task automatic press(input int idx);
        set_sw(idx, 1'b1);
        repeat (DB + 8) @(negedge clk);
        set_sw(idx, 1'b0);
        repeat (DB + 8) @(negedge clk);
    endtask

    task automatic wait_req(input string name);
        int k = 0;
        while (!mem_req && k < 80) begin
            @(negedge clk);
            k++;
        end
        chk(name, mem_req, 1'b1);
    endtask

    // memory responder: acks a request after a short latency, or a forced stray ack
    always @(negedge clk) begin
        mem_ack = 1'b0;
        if (inject_ack) begin
            mem_ack   = 1'b1;
            mem_rdata = 8'hEE;
            pending   = 1'b0;
        end else if (ack_en && mem_req) begin
            if (!pending) begin
                pending = 1'b1;
                lat     = 2;
            end else if (lat > 0) begin
                lat--;
            end else begin
                mem_ack = 1'b1;
                if (mem_we) mem[mem_addr] = mem_wdata;
                mem_rdata = mem[mem_addr];
                pending   = 1'b0;
            end
        end else begin
            pending = 1'b0;
        end
    end

    // CPU model: goes busy for a long while after each single step
    always @(negedge clk) begin
        if (cpu_model_en) begin
            if (cpu_step) busy_cnt = 80;
            if (busy_cnt > 0) begin
                cpu_idle = 1'b0;
                busy_cnt--;
            end else begin
                cpu_idle = 1'b1;
            end
        end
    end

    // request scoreboard and pulse-width monitors
    always @(negedge clk) begin
        if (mem_req && !req_prev) begin
            req_count++;
            chk("req_expected", 32'(sb_q.size() != 0), 1);
            chk("req_owns_bus", panel_owns_bus, 1'b1);
            if (sb_q.size() != 0) begin
                t = sb_q.pop_front();
                chk("req_txn", {mem_we, mem_addr, mem_we ? mem_wdata : 8'h00}, t);
            end
        end else if (mem_req && req_prev) begin
            chk("req_stable", {mem_we, mem_addr, mem_wdata}, req_snap);
        end
        req_prev = mem_req;
        req_snap = {mem_we, mem_addr, mem_wdata};
        if (cpu_step) begin
            step_run++;
            if (step_run == 1) step_pulses++;
        end else step_run = 0;
        if (step_run > step_wmax) step_wmax = step_run;
        if (io_clear) begin
            clr_run++;
            if (clr_run == 1) clr_pulses++;
        end else clr_run = 0;
        if (clr_run > clr_wmax) clr_wmax = clr_run;
        if (cpu_reset) rst_run++;
        else begin
            if (rst_run > 0) rst_last = rst_run;
            rst_run = 0;
        end
    end

    initial begin
        vecs[0] = '{3'd1, 8'h12, 8'h34, 8'hA5, 16'h1234, 8'hA5};
        vecs[1] = '{3'd2, 8'h00, 8'h00, 8'h3C, 16'h1235, 8'h3C};
        vecs[2] = '{3'd3, 8'h00, 8'h77, 8'h00, 16'h1235, 8'h77};
        vecs[3] = '{3'd4, 8'h00, 8'h88, 8'h00, 16'h1236, 8'h88};
        vecs[4] = '{3'd1, 8'hFF, 8'hFF, 8'hE1, 16'hFFFF, 8'hE1};
        vecs[5] = '{3'd4, 8'h00, 8'h5A, 8'h00, 16'h0000, 8'h5A};
        vecs[6] = '{3'd2, 8'h00, 8'h00, 8'h0F, 16'h0001, 8'h0F};

        reset = 1'b1; on_off_sw = 1'b0; stop_run_sw = 1'b0;
        step_sw = 0; examine_sw = 0; examine_next_sw = 0; deposit_sw = 0;
        deposit_next_sw = 0; reset_sw = 0; clear_sw = 0;
        sense_addr_sw = 8'h00; data_addr_sw = 8'h00; cpu_idle = 1'b1;
        mem_ack = 1'b0; mem_rdata = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {cpu_run, cpu_step, cpu_reset, io_clear, panel_owns_bus, mem_req, mem_we, wait_led}, 8'h01);
        chk("rst_addr", mem_addr, 16'h0000);
        chk("rst_wdata", mem_wdata, 8'h00);
        chk("rst_pdata", panel_data, 8'h00);
        chk("rst_paddr", panel_addr, 16'h0000);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            sense_addr_sw = vecs[i].sense;
            data_addr_sw  = vecs[i].data;
            if (vecs[i].sw == 3'd3 || vecs[i].sw == 3'd4) begin
                sb_q.push_back({1'b1, vecs[i].addr, vecs[i].data});
                sb_q.push_back({1'b0, vecs[i].addr, 8'h00});
            end else begin
                mem[vecs[i].addr] = vecs[i].pre;
                sb_q.push_back({1'b0, vecs[i].addr, 8'h00});
            end
            press(int'(vecs[i].sw));
            repeat (10) @(negedge clk);
            chk($sformatf("vec%0d_pdata", i), panel_data, vecs[i].pdata);
            chk($sformatf("vec%0d_addr", i), mem_addr, vecs[i].addr);
            chk($sformatf("vec%0d_paddr", i), panel_addr, vecs[i].addr);
            chk($sformatf("vec%0d_idle", i), {mem_req, panel_owns_bus, wait_led}, 3'b001);
        end
        chk("table_sb_empty", sb_q.size(), 0);

        // bouncing contact then a clean hold: one read only
        sense_addr_sw = 8'h00; data_addr_sw = 8'h10; mem[16'h0010] = 8'h42;
        sb_q.push_back({1'b0, 16'h0010, 8'h00});
        r0 = req_count;
        for (int k = 0; k < 20; k++) begin
            set_sw(1, ((k / 3) % 2) == 0);
            @(negedge clk);
        end
        press(1);
        repeat (10) @(negedge clk);
        chk("bounce_reqs", req_count - r0, 1);
        chk("bounce_pdata", panel_data, 8'h42);

        // single step; a second press while the CPU is busy is dropped
        p0 = step_pulses;
        set_sw(0, 1'b1);
        n = 0;
        while (step_pulses == p0 && n < 80) begin @(negedge clk); n++; end
        chk("step_fired", step_pulses, p0 + 1);
        set_sw(0, 1'b0);
        repeat (DB + 6) @(negedge clk);
        set_sw(0, 1'b1);
        repeat (DB + 6) @(negedge clk);
        set_sw(0, 1'b0);
        repeat (DB + 6) @(negedge clk);
        chk("step_ignored", step_pulses, p0 + 1);
        repeat (40) @(negedge clk);
        press(0);
        chk("step_again", step_pulses, p0 + 2);
        chk("step_width", step_wmax, 1);
        chk("step_owns", panel_owns_bus, 1'b0);
        repeat (100) @(negedge clk);

        // arbitration: examine waits for the CPU to go idle
        cpu_model_en = 1'b0; cpu_idle = 1'b0;
        sense_addr_sw = 8'h20; data_addr_sw = 8'h00; mem[16'h2000] = 8'h99;
        sb_q.push_back({1'b0, 16'h2000, 8'h00});
        viol = 0;
        set_sw(1, 1'b1);
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (mem_req || panel_owns_bus) viol++;
        end
        chk("arb_blocked", viol, 0);
        cpu_idle = 1'b1;
        @(negedge clk);
        chk("arb_req_after_grant", {mem_req, panel_owns_bus}, 2'b11);
        set_sw(1, 1'b0);
        repeat (DB + 8) @(negedge clk);
        chk("arb_pdata", panel_data, 8'h99);
        cpu_model_en = 1'b1;

        // running: memory commands ignored, clear still works
        stop_run_sw = 1'b1;
        repeat (DB + 6) @(negedge clk);
        chk("run_on", {cpu_run, wait_led}, 2'b10);
        r0 = req_count;
        press(1);
        chk("run_exam_ignored", req_count - r0, 0);
        c0 = clr_pulses;
        press(5);
        chk("clear_pulse", clr_pulses, c0 + 1);
        chk("clear_width", clr_wmax, 1);
        stop_run_sw = 1'b0;
        repeat (DB + 6) @(negedge clk);
        chk("run_off", {cpu_run, wait_led}, 2'b01);

        // reset switch while a write is waiting for its ack
        ack_en = 1'b0;
        data_addr_sw = 8'h66;
        sb_q.push_back({1'b1, 16'h2000, 8'h66});
        set_sw(3, 1'b1);
        wait_req("rmw_req_seen");
        set_sw(3, 1'b0);
        repeat (5) @(negedge clk);
        chk("rmw_req_held", mem_req, 1'b1);
        set_sw(6, 1'b1);
        n = 0;
        while (!cpu_reset && n < 80) begin @(negedge clk); n++; end
        chk("rmw_abandon", {cpu_reset, mem_req, panel_owns_bus}, 3'b100);
        n = 0;
        while (cpu_reset && n < 40) begin @(negedge clk); n++; end
        @(negedge clk);
        chk("rmw_rst_width", rst_last, RC);
        chk("rmw_addr", mem_addr, 16'h0000);
        chk("rmw_pdata", panel_data, 8'h00);
        @(posedge clk); #2 inject_ack = 1'b1;
        @(posedge clk); #2 inject_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("late_ack_ignored", {mem_req, panel_data}, 9'h000);
        set_sw(6, 1'b0);
        repeat (DB + 8) @(negedge clk);

        // panel switched off mid-read
        sense_addr_sw = 8'h30; data_addr_sw = 8'h00;
        sb_q.push_back({1'b0, 16'h3000, 8'h00});
        set_sw(1, 1'b1);
        wait_req("off_req_seen");
        set_sw(1, 1'b0);
        on_off_sw = 1'b1;
        @(negedge clk);
        chk("off_ctrl", {cpu_run, cpu_step, cpu_reset, io_clear, panel_owns_bus, mem_req, mem_we, wait_led}, 8'h01);
        chk("off_addr", mem_addr, 16'h0000);
        repeat (5) @(negedge clk);
        on_off_sw = 1'b0;
        ack_en = 1'b1;
        r0 = req_count;
        repeat (DB + 10) @(negedge clk);
        chk("off_no_req", req_count - r0, 0);
        chk("final_sb_empty", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/front_panel_sequencer.md
# front_panel_sequencer

Sequences Altair front-panel operator actions into CPU control and memory bus cycles. Sits between the decoded panel switch outputs and the CPU/memory subsystem. Debounces and edge-detects the momentary switches, and arbitrates the memory port between the CPU and the panel. Performs examine, examine-next, deposit, deposit-next, single-step, reset and clear, and holds the address/data latches that drive the panel LEDs.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 16: cycles a raw switch level must be stable before it is accepted (≥1).
- RESET_CYCLES, 8: width of the cpu_reset pulse (≥1).

Ports (bit 0 = LSB on all buses):
- clk  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- on_off_sw  in  1  1 = panel off; holds the block in its reset state.
- stop_run_sw  in  1  level; 1 = run, 0 = stop.
- step_sw, examine_sw, examine_next_sw, deposit_sw, deposit_next_sw, reset_sw, clear_sw  in  1 each  momentary, active-high.
- sense_addr_sw  in  8  address A15..A8.
- data_addr_sw  in  8  address A7..A0 and deposit data.
- cpu_idle  in  1  CPU is at an instruction boundary and its bus is free.
- cpu_run  out  1  CPU may execute continuously.
- cpu_step  out  1  one-cycle pulse; CPU executes exactly one instruction.
- cpu_reset  out  1  CPU reset pulse.
- io_clear  out  1  one-cycle I/O clear pulse.
- panel_owns_bus  out  1  memory mux select: 1 = panel, 0 = CPU.
- mem_req  out  1  panel memory request.
- mem_we  out  1  1 = write.
- mem_addr  out  16  panel address latch.
- mem_wdata  out  8  write data.
- mem_ack  in  1  one-cycle completion strobe.
- mem_rdata  in  8  valid when mem_ack = 1.
- panel_addr  out  16  address LED value.
- panel_data  out  8  data LED value.
- wait_led  out  1  1 when the CPU is not running.

## Operation
- Every control input passes through a 2-flop synchroniser and then a debouncer. A command fires on the rising edge of the debounced level, so each press produces exactly one event.
- One event is accepted per cycle, by priority: reset > clear > deposit_next > deposit > examine_next > examine > step. Lower-priority events arriving in the same cycle are discarded.
- While the FSM is not in IDLE, new events other than reset are discarded.
- stop_run_sw = 1 and the FSM in IDLE gives cpu_run = 1. While running, only reset and clear are accepted.
- stop_run_sw falling: cpu_run drops the next cycle.
- FSM states:
  - IDLE: no operation in progress; entry point for all commands.
  - GRANT: waits for cpu_idle = 1, then sets panel_owns_bus = 1 and moves to the pending operation.
  - EXAM:
    - examine: mem_addr = {sense_addr_sw, data_addr_sw}.
    - examine_next: mem_addr = mem_addr + 1, wrapping FFFF to 0000.
    - Then issues a read.
  - DEP:
    - deposit: mem_addr unchanged.
    - deposit_next: mem_addr + 1 with the same wrap.
    - Writes data_addr_sw, then moves to READBACK.
  - READBACK: reads the same address so panel_data shows the stored byte.
  - STEP: pulses cpu_step and drops panel_owns_bus; waits for cpu_idle to deassert, then reassert; returns to IDLE.
  - RST: holds cpu_reset for RESET_CYCLES, clears mem_addr to 0000 and panel_data to 00, drops panel_owns_bus.
- Memory handshake:
  - mem_req rises with mem_addr, mem_we and mem_wdata valid, and all four stay constant until mem_ack.
  - mem_req drops in the cycle after mem_ack.
  - Only one request is outstanding at a time.
  - On a read ack: panel_data <= mem_rdata.
- panel_addr = mem_addr while stopped, and follows nothing else. wait_led = ~cpu_run.
- clear: one-cycle io_clear pulse from IDLE; no state change otherwise.

## Timing
- Reset, or on_off_sw = 1: FSM in IDLE, all pulses 0, cpu_run = 0, panel_owns_bus = 0, mem_req = 0, mem_we = 0, mem_addr = 0000, mem_wdata = 00, panel_data = 00, wait_led = 1, debouncers cleared.
- Press to event: 2 synchroniser cycles + DEBOUNCE_CYCLES.
- Event to mem_req when cpu_idle is already 1: 2 cycles (IDLE→GRANT→EXAM/DEP).
- mem_ack in cycle N: panel_data updates at N+1; FSM returns to IDLE, or enters READBACK, at N+1.
- mem_ack arriving without mem_req is ignored.
- reset_sw during any state, including mid memory cycle:
  - mem_req is abandoned the next cycle.
  - A late mem_ack is ignored.
  - Enters RST.
- Global reset mid-operation: same abandonment; outputs return to reset values next cycle.
- cpu_step pulse is exactly 1 cycle.

## Test plan
- Examine: set sense = 12h, data = 34h, press examine, memory returns A5h -> mem_addr = 1234h, mem_we = 0, one mem_req; panel_data = A5h one cycle after ack.
- Deposit-next with wrap: mem_addr = FFFFh, data = 5Ah, press deposit_next -> write 5Ah at 0000h, then a read of 0000h; panel_addr = 0000h, panel_data = 5Ah.
- Bounce: toggle examine every 3 cycles for 20 cycles with DEBOUNCE_CYCLES = 16, then hold -> exactly one read cycle.
- Arbitration: press examine with cpu_idle = 0 for 50 cycles -> no mem_req and panel_owns_bus = 0 until cpu_idle rises; mem_req 1 cycle after the grant.
- Step: stopped, press step -> single 1-cycle cpu_step; a second step during the wait is ignored.
- Reset mid-write: assert reset_sw while mem_req = 1 and ack is pending -> mem_req drops, cpu_reset high for 8 cycles, mem_addr = 0000h, a later ack is ignored.
